hwmod_rst_ctrl: RTL

Parametrised reset controller for the hardware security monitors (VRASED, CASU, GAROTA and successors). It replaces the flat OR of per-monitor reset requests with a registered combiner supporting NUM_MON channels, a per-channel enable mask, and a minimum reset-hold stretch. It adds sticky lock-out for channels marked fatal and first-fault forensics (cause bits, PC, data address, violation count). Sits between the monitor instances and the openMSP430 reset input.

---
 rtl/hwmod_pkg.sv | 30 +++
 rtl/hwmod_hold_ctr.sv | 36 +++
 rtl/hwmod_rst_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/hwmod_pkg.sv
// +----------------------------------------------------------------------------+
// | hwmod_pkg                                                                  |
// | Shared state encodings and trusted-memory defaults for the hwmod monitors. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package hwmod_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HOLD = 2'b01,
    ST_LOCK = 2'b10
  } state_t;

  localparam logic [15:0] C_SMEM_BASE_DEF = 16'hA000;
  localparam logic [15:0] C_SMEM_SIZE_DEF = 16'h4000;

  // Offset compare keeps the range check free of 16-bit wrap at the top.
  function automatic logic in_smem(input logic [15:0] addr,
                                   input logic [15:0] base,
                                   input logic [15:0] size);
    logic [15:0] off;
    off = addr - base;
    return (off < size);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hwmod_hold_ctr.sv
// +----------------------------------------------------------------------------+
// | hwmod_hold_ctr                                                             |
// | Reset-hold stretch counter: load RST_CYCLES-1, decrement, zero flag.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module hwmod_hold_ctr #(
  parameter int RST_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int C_CW = $clog2(RST_CYCLES + 1);

  logic [C_CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= C_CW'(RST_CYCLES - 1);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - C_CW'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/hwmod_rst_ctrl.sv
// +----------------------------------------------------------------------------+
// | hwmod_rst_ctrl                                                             |
// | Registered reset combiner for the security monitors with hold stretch,    |
// | sticky lock-out and first-fault forensics.                                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module hwmod_rst_ctrl
  import hwmod_pkg::*;
#(
  parameter int                  NUM_MON     = 3,
  parameter logic [NUM_MON-1:0]  EN_MASK     = '1,
  parameter logic [NUM_MON-1:0]  STICKY_MASK = '0,
  parameter int                  RST_CYCLES  = 8,
  parameter int                  CNT_W       = 8,
  parameter logic [15:0]         SMEM_BASE   = C_SMEM_BASE_DEF,
  parameter logic [15:0]         SMEM_SIZE   = C_SMEM_SIZE_DEF
) (
  input  logic               clk,
  input  logic               puc_rst,
  input  logic [NUM_MON-1:0] mon_req,
  input  logic [15:0]        pc,
  input  logic [15:0]        data_addr,
  input  logic               clr,
  output logic               reset_out,
  output logic               locked,
  output logic [NUM_MON-1:0] cause_first,
  output logic [NUM_MON-1:0] cause_all,
  output logic [15:0]        fault_pc,
  output logic [15:0]        fault_addr,
  output logic [CNT_W-1:0]   viol_cnt
);

  state_t             r_state;
  state_t             w_nxt;
  logic               w_load;
  logic               w_dec;
  logic               w_zero;
  logic [NUM_MON-1:0] w_req;
  logic               w_any;
  logic               w_fatal;
  logic               w_leave_run;
  logic               w_clr_ok;

  logic               r_reset_out;
  logic               r_locked;
  logic [NUM_MON-1:0] r_cause_first;
  logic [NUM_MON-1:0] r_cause_all;
  logic [15:0]        r_fault_pc;
  logic [15:0]        r_fault_addr;
  logic [CNT_W-1:0]   r_viol_cnt;

  assign w_req   = mon_req & EN_MASK;
  assign w_any   = |w_req;
  assign w_fatal = |(w_req & STICKY_MASK);

  always_comb begin
    w_nxt  = r_state;
    w_load = 1'b0;
    w_dec  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_fatal) begin
          w_nxt = ST_LOCK;
        end else if (w_any) begin
          w_nxt  = ST_HOLD;
          w_load = 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_fatal) begin
          w_nxt = ST_LOCK;
        end else if (w_any) begin
          w_load = 1'b1;
        end else if (w_zero) begin
          w_nxt = ST_RUN;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_LOCK: w_nxt = ST_LOCK;
      // Unused encoding is treated as a fatal condition.
      default: w_nxt = ST_LOCK;
    endcase
  end

  assign w_leave_run = (r_state == ST_RUN) && (w_nxt != ST_RUN);
  assign w_clr_ok    = clr && (r_state == ST_RUN) && !w_any &&
                       in_smem(pc, SMEM_BASE, SMEM_SIZE);

  hwmod_hold_ctr #(
    .RST_CYCLES (RST_CYCLES)
  ) u_hold_ctr (
    .clk    (clk),
    .rst    (puc_rst),
    .i_load (w_load),
    .i_dec  (w_dec),
    .o_zero (w_zero)
  );

  always_ff @(posedge clk or posedge puc_rst) begin
    if (puc_rst) begin
      r_state       <= ST_RUN;
      r_reset_out   <= 1'b0;
      r_locked      <= 1'b0;
      r_cause_first <= '0;
      r_cause_all   <= '0;
      r_fault_pc    <= '0;
      r_fault_addr  <= '0;
      r_viol_cnt    <= '0;
    end else begin
      r_state     <= w_nxt;
      r_reset_out <= (w_nxt != ST_RUN);
      r_locked    <= (w_nxt == ST_LOCK);

      if (w_clr_ok) begin
        r_cause_all <= '0;
      end else begin
        r_cause_all <= r_cause_all | w_req;
      end

      if (w_leave_run) begin
        if (r_cause_first == '0) begin
          r_cause_first <= w_req;
          r_fault_pc    <= pc;
          r_fault_addr  <= data_addr;
        end
        if (r_viol_cnt != '1) begin
          r_viol_cnt <= r_viol_cnt + CNT_W'(1);
        end
      end else if (w_clr_ok) begin
        r_cause_first <= '0;
        r_fault_pc    <= '0;
        r_fault_addr  <= '0;
        r_viol_cnt    <= '0;
      end
    end
  end

  assign reset_out   = r_reset_out;
  assign locked      = r_locked;
  assign cause_first = r_cause_first;
  assign cause_all   = r_cause_all;
  assign fault_pc    = r_fault_pc;
  assign fault_addr  = r_fault_addr;
  assign viol_cnt    = r_viol_cnt;

endmodule

`default_nettype wire
